cpu_run_monitor: RTL and testbench

- Synthesizable run controller and observer for the single-cycle/pipelined `cpu` core. It is the consumer end of the core's `pc`/`hlt` interface.
- Sequences the core's active-low `rst_n` after a system reset.
- Counts execution cycles from core reset release to halt, and detects halt with a pipeline-drain window and a watchdog timeout.
- Captures a PC-change trace into a FIFO that a host or debug port drains through a valid/ready handshake.

---
 rtl/cpu_run_monitor.sv | 137 +++++++++++++
 tb/tb_cpu_run_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: sequences core reset, measures run cycles to halt, watchdogs and traces PC changes.
// Define RUN_MON_TRACE_EN to build the PC-change trace FIFO; without it the trace outputs are tied off.
module cpu_run_monitor #(
  parameter int RST_HOLD_CYCLES = 3,
  parameter int DRAIN_CYCLES    = 3,
  parameter int TIMEOUT_CYCLES  = 25000,
  parameter int TRACE_DEPTH     = 16,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      pc,
  input  logic             hlt,
  output logic             cpu_rst_n,
  input  logic             trace_rd,
  output logic             trace_valid,
  output logic [15:0]      trace_pc,
  output logic             trace_overflow,
  output logic [CNT_W-1:0] cycle_count,
  output logic [15:0]      final_pc,
  output logic             done,
  output logic             timed_out,
  output logic [2:0]       state
);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 2);
  typedef enum logic [2:0] {HOLD = 3'd0, RUN = 3'd1, DRAIN = 3'd2, DONE = 3'd3, TMO = 3'd4} state_t;
  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      fpc_q, fpc_d;
  logic             rstn_q, done_q, done_d, to_q, to_d;
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    fpc_d   = fpc_q;
    done_d  = done_q;
    to_d    = to_q;
    case (state_q)
      HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HW'(RST_HOLD_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        // halt takes priority over a watchdog expiring on the same cycle
        if (hlt) begin
          fpc_d   = pc;
          state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
          done_d  = (DRAIN_CYCLES == 0);
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = TMO;
          to_d    = 1'b1;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_d == DW'(DRAIN_CYCLES)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      hold_q  <= '0;
      drain_q <= '0;
      cnt_q   <= '0;
      fpc_q   <= '0;
      rstn_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
      fpc_q   <= fpc_d;
      rstn_q  <= (state_d != HOLD);
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end
  assign cpu_rst_n   = rstn_q;
  assign cycle_count = cnt_q;
  assign final_pc    = fpc_q;
  assign done        = done_q;
  assign timed_out   = to_q;
  assign state       = state_q;
`ifdef RUN_MON_TRACE_EN
  localparam int AW = $clog2(TRACE_DEPTH);
  logic [15:0] mem_q [TRACE_DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic [15:0] last_q;
  logic        last_v_q, ovf_q, push, pop, wr, empty, full;
  assign push  = (state_q == RUN) && (!last_v_q || pc != last_q);
  assign empty = (wp_q == rp_q);
  assign full  = ((wp_q ^ rp_q) == {1'b1, {AW{1'b0}}});
  assign pop   = trace_rd && !empty;
  assign wr    = push && (!full || pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q     <= '0;
      rp_q     <= '0;
      last_q   <= '0;
      last_v_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        last_q   <= pc;
        last_v_q <= 1'b1;
      end
      if (wr) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q[AW-1:0]] <= pc;
  end
  assign trace_valid    = !empty;
  assign trace_pc       = empty ? '0 : mem_q[rp_q[AW-1:0]];
  assign trace_overflow = ovf_q;
`else
  logic unused_trace_rd;
  assign unused_trace_rd = trace_rd;
  assign trace_valid     = 1'b0;
  assign trace_pc        = '0;
  assign trace_overflow  = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: scenario tasks plus randomized run against a queue-based behavioural model.
module tb_cpu_run_monitor;
  localparam int HOLD = 3, DRN = 3, TMO = 10, DEPTH = 4, CW = 32;
`ifdef RUN_MON_TRACE_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  logic clk = 0, rst = 1, hlt = 0, trace_rd = 0;
  logic [15:0] pc = 0;
  logic cpu_rst_n, trace_valid, trace_overflow, done, timed_out;
  logic [15:0] trace_pc, final_pc;
  logic [CW-1:0] cycle_count;
  logic [2:0] state;
  logic z_rst_n, z_valid, z_ovf, z_done, z_to;
  logic [15:0] z_tpc, z_fpc;
  logic [CW-1:0] z_cnt;
  logic [2:0] z_state;
  int checks = 0, errors = 0;
  int m_st, m_hold, m_drain, m_done, m_to, m_ovf, m_lv;
  longint m_cnt;
  logic [15:0] m_fpc, m_last;
  logic [15:0] m_q[$];

  cpu_run_monitor #(.RST_HOLD_CYCLES(HOLD), .DRAIN_CYCLES(DRN), .TIMEOUT_CYCLES(TMO),
                    .TRACE_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .hlt(hlt), .cpu_rst_n(cpu_rst_n), .trace_rd(trace_rd),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_overflow(trace_overflow),
    .cycle_count(cycle_count), .final_pc(final_pc), .done(done), .timed_out(timed_out), .state(state));

  cpu_run_monitor #(.RST_HOLD_CYCLES(HOLD), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(TMO),
                    .TRACE_DEPTH(DEPTH), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .pc(pc), .hlt(hlt), .cpu_rst_n(z_rst_n), .trace_rd(trace_rd),
    .trace_valid(z_valid), .trace_pc(z_tpc), .trace_overflow(z_ovf),
    .cycle_count(z_cnt), .final_pc(z_fpc), .done(z_done), .timed_out(z_to), .state(z_state));

  always #5 clk = ~clk;

  task automatic model_step();
    bit pop, push;
    if (rst) begin
      m_st = 0; m_hold = 0; m_drain = 0; m_cnt = 0; m_fpc = 0; m_done = 0; m_to = 0;
      m_ovf = 0; m_lv = 0; m_last = 0; m_q.delete();
      return;
    end
    pop  = TEN && trace_rd && m_q.size() > 0;
    push = TEN && m_st == 1 && (!m_lv || pc != m_last);
    if (push) begin m_last = pc; m_lv = 1; end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(pc);
      else m_ovf = 1;
    end
    case (m_st)
      0: begin m_hold++; if (m_hold == HOLD) m_st = 1; end
      1: begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (hlt) begin
          m_fpc = pc; m_drain = 0;
          if (DRN == 0) begin m_st = 3; m_done = 1; end else m_st = 2;
        end else if (m_cnt == TMO) begin m_st = 4; m_to = 1; end
      end
      2: begin m_drain++; if (m_drain == DRN) begin m_st = 3; m_done = 1; end end
      default: ;
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_run();
    rst = 1; hlt = 0; trace_rd = 0;
    tick();
    rst = 0;
    repeat (HOLD) tick();
  endtask

  task automatic test_reset();
    rst = 1; pc = 16'h1234; hlt = 1;
    tick(); tick();
    hlt = 0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (cpu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_rstn got %b want 0", cpu_rst_n); end
    checks++; if (cycle_count !== 0 || final_pc !== 0) begin errors++; $display("FAIL reset_cnt got %0d/%h want 0/0", cycle_count, final_pc); end
    checks++; if ({done, timed_out, trace_valid, trace_overflow} !== 4'b0 || trace_pc !== 0) begin
      errors++; $display("FAIL reset_flags got %b%b%b%b pc %h want 0000 pc 0", done, timed_out, trace_valid, trace_overflow, trace_pc); end
    rst = 0;
    for (int e = 1; e <= HOLD; e++) begin
      tick();
      checks++; if (cpu_rst_n !== (e == HOLD)) begin errors++; $display("FAIL hold_rstn edge %0d got %b want %b", e, cpu_rst_n, e == HOLD); end
    end
    checks++; if (state !== 3'd1 || cycle_count !== 0) begin errors++; $display("FAIL run_entry got st %0d cnt %0d want 1/0", state, cycle_count); end
  endtask

  task automatic test_halt_trace();
    logic [15:0] seq [5] = '{16'h0, 16'h2, 16'h4, 16'h4, 16'h6};
    logic [15:0] exp [4] = '{16'h0, 16'h2, 16'h4, 16'h6};
    go_run();
    for (int i = 0; i < 5; i++) begin pc = seq[i]; hlt = (i == 4); tick(); end
    hlt = 0;
    checks++; if (state !== 3'd2 || final_pc !== 16'h6 || cycle_count !== 5) begin
      errors++; $display("FAIL halt_capture got st %0d fpc %h cnt %0d want 2/0006/5", state, final_pc, cycle_count); end
    checks++; if (z_state !== 3'd3 || z_done !== 1'b1) begin errors++; $display("FAIL drain0_done got st %0d done %b want 3/1", z_state, z_done); end
    for (int k = 1; k <= DRN; k++) begin
      pc = 16'($urandom); hlt = 1'($urandom);
      tick();
      checks++; if (done !== (k == DRN)) begin errors++; $display("FAIL drain_done k %0d got %b want %b", k, done, k == DRN); end
    end
    hlt = 0;
    checks++; if (state !== 3'd3 || cycle_count !== 5 || final_pc !== 16'h6) begin
      errors++; $display("FAIL done_hold got st %0d cnt %0d fpc %h want 3/5/0006", state, cycle_count, final_pc); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (trace_valid !== TEN || trace_pc !== (TEN ? exp[i] : 16'h0)) begin
        errors++; $display("FAIL halt_pop %0d got v%b %h want v%b %h", i, trace_valid, trace_pc, TEN, TEN ? exp[i] : 16'h0); end
      trace_rd = 1; tick(); trace_rd = 0;
    end
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL halt_empty got %b want 0", trace_valid); end
  endtask

  task automatic test_timeout();
    go_run();
    pc = 16'h100;
    repeat (TMO - 1) tick();
    checks++; if (state !== 3'd1 || cycle_count !== TMO - 1) begin errors++; $display("FAIL pre_timeout got st %0d cnt %0d want 1/%0d", state, cycle_count, TMO - 1); end
    tick();
    checks++; if (state !== 3'd4 || timed_out !== 1'b1 || cycle_count !== TMO || done !== 1'b0) begin
      errors++; $display("FAIL timeout got st %0d to %b cnt %0d done %b want 4/1/%0d/0", state, timed_out, cycle_count, done, TMO); end
    pc = 16'h200; hlt = 1; tick(); hlt = 0; tick(); tick();
    checks++; if (state !== 3'd4 || cycle_count !== TMO || done !== 1'b0 || final_pc !== 16'h0) begin
      errors++; $display("FAIL timeout_sticky got st %0d cnt %0d done %b fpc %h want 4/%0d/0/0000", state, cycle_count, done, final_pc, TMO); end
  endtask

  task automatic test_hlt_at_limit();
    go_run();
    repeat (TMO - 1) tick();
    pc = 16'hBEEF; hlt = 1; tick(); hlt = 0;
    checks++; if (state !== 3'd2 || timed_out !== 1'b0 || cycle_count !== TMO || final_pc !== 16'hBEEF) begin
      errors++; $display("FAIL hlt_limit got st %0d to %b cnt %0d fpc %h want 2/0/%0d/beef", state, timed_out, cycle_count, final_pc, TMO); end
    repeat (DRN) tick();
    checks++; if (state !== 3'd3 || done !== 1'b1 || timed_out !== 1'b0) begin
      errors++; $display("FAIL hlt_limit_done got st %0d done %b to %b want 3/1/0", state, done, timed_out); end
  endtask

  task automatic test_overflow();
    go_run();
    for (int i = 0; i < 6; i++) begin pc = 16'hA000 + 16'(i); tick(); end
    checks++; if (trace_overflow !== TEN || trace_valid !== TEN) begin
      errors++; $display("FAIL overflow got ovf %b v %b want %b/%b", trace_overflow, trace_valid, TEN, TEN); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (trace_pc !== (TEN ? 16'hA000 + 16'(i) : 16'h0)) begin
        errors++; $display("FAIL ovf_pop %0d got %h want %h", i, trace_pc, TEN ? 16'hA000 + 16'(i) : 16'h0); end
      trace_rd = 1; tick(); trace_rd = 0;
    end
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", trace_valid); end
    go_run();
    for (int i = 0; i < 5; i++) begin pc = 16'hB000 + 16'(i); trace_rd = (i == 4); tick(); end
    trace_rd = 0;
    checks++; if (trace_overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf got %b want 0", trace_overflow); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (trace_valid !== TEN || trace_pc !== (TEN ? 16'hB000 + 16'(i) : 16'h0)) begin
        errors++; $display("FAIL pushpop_pop %0d got v%b %h want v%b %h", i, trace_valid, trace_pc, TEN, TEN ? 16'hB000 + 16'(i) : 16'h0); end
      trace_rd = 1; tick(); trace_rd = 0;
    end
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty got %b want 0", trace_valid); end
  endtask

  task automatic test_mid_reset();
    go_run();
    for (int i = 0; i < 7; i++) begin pc = 16'hC000 + 16'(i); tick(); end
    checks++; if (cycle_count !== 7 || trace_overflow !== TEN) begin errors++; $display("FAIL pre_midrst got cnt %0d ovf %b want 7/%b", cycle_count, trace_overflow, TEN); end
    rst = 1; tick(); rst = 0;
    checks++; if (state !== 3'd0 || cpu_rst_n !== 1'b0 || cycle_count !== 0 || trace_valid !== 1'b0 || trace_overflow !== 1'b0) begin
      errors++; $display("FAIL midrst got st %0d rstn %b cnt %0d v %b ovf %b want 0/0/0/0/0", state, cpu_rst_n, cycle_count, trace_valid, trace_overflow); end
    for (int e = 1; e <= HOLD; e++) begin
      tick();
      checks++; if (cpu_rst_n !== (e == HOLD)) begin errors++; $display("FAIL midrst_hold edge %0d got %b want %b", e, cpu_rst_n, e == HOLD); end
    end
  endtask

  task automatic test_random();
    logic [15:0] epc;
    rst = 1; tick(); rst = 0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, m_st >= 3 ? 4 : 60) == 0);
      pc = 16'($urandom_range(0, 3) * 2);
      hlt = ($urandom_range(0, 14) == 0);
      trace_rd = 1'($urandom);
      tick();
      epc = (m_q.size() > 0) ? m_q[0] : 16'h0;
      checks++; if (state !== 3'(m_st) || cpu_rst_n !== (m_st != 0) || cycle_count !== CW'(m_cnt) || final_pc !== m_fpc) begin
        errors++; $display("FAIL rnd_ctrl n %0d got st %0d rstn %b cnt %0d fpc %h want %0d/%b/%0d/%h", n, state, cpu_rst_n, cycle_count, final_pc, m_st, m_st != 0, m_cnt, m_fpc); end
      checks++; if (done !== 1'(m_done) || timed_out !== 1'(m_to)) begin
        errors++; $display("FAIL rnd_flags n %0d got done %b to %b want %0d/%0d", n, done, timed_out, m_done, m_to); end
      checks++; if (trace_valid !== (m_q.size() > 0) || trace_pc !== epc || trace_overflow !== 1'(m_ovf)) begin
        errors++; $display("FAIL rnd_trace n %0d got v%b %h ovf %b want v%b %h ovf %0d", n, trace_valid, trace_pc, trace_overflow, m_q.size() > 0, epc, m_ovf); end
    end
    rst = 0; hlt = 0; trace_rd = 0;
  endtask

  initial begin
    test_reset();
    test_halt_trace();
    test_timeout();
    test_hlt_at_limit();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
